// File: rtl/des_key_sequencer.sv
// DES key-schedule front end: PC-1 on load, then one rotated C/D pair per cycle,
// with PC-2 applied combinationally to stream K1..K16 (or K16..K1 via right rotation).
module des_key_sequencer #(
    parameter bit PARITY_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic [47:0] rk_out,
    output logic [4:0]  rk_round,
    output logic        rk_last,
    output logic        busy,
    output logic        parity_err
);

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Vectors are MSB-first in FIPS numbering: DES bit n of a W-bit word sits at [W-n].
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_T[i]];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_T[i]];
        return r;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // Rounds 1, 2, 9 and 16 shift by one; every other round shifts by two.
    function automatic logic shift_two(input logic [4:0] r);
        return !(r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16);
    endfunction

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q;
    logic [27:0] c_q, d_q;
    logic [4:0]  round_q;
    logic        dec_q;
    logic        valid_q, busy_q, last_q, perr_q;

    logic [55:0] cd0;
    logic [27:0] c_d, d_d;
    logic [27:0] c0_d, d0_d;
    logic [4:0]  round_d;
    logic        last_d;
    logic        perr_d;

    always_comb begin
        cd0    = pc1(key_in);
        c0_d   = decrypt ? cd0[55:28] : rotl(cd0[55:28], 1'b0);
        d0_d   = decrypt ? cd0[27:0]  : rotl(cd0[27:0],  1'b0);
        perr_d = 1'b0;
        for (int b = 0; b < 8; b++) perr_d = perr_d | ~^key_in[8*b +: 8];
        if (dec_q) begin
            round_d = round_q - 5'd1;
            c_d     = rotr(c_q, shift_two(round_q));
            d_d     = rotr(d_q, shift_two(round_q));
            last_d  = (round_d == 5'd1);
        end else begin
            round_d = round_q + 5'd1;
            c_d     = rotl(c_q, shift_two(round_d));
            d_d     = rotl(d_q, shift_two(round_d));
            last_d  = (round_d == 5'd16);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            dec_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (key_valid) begin
                        c_q     <= c0_d;
                        d_q     <= d0_d;
                        dec_q   <= decrypt;
                        round_q <= decrypt ? 5'd16 : 5'd1;
                        last_q  <= 1'b0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        perr_q  <= PARITY_CHECK ? perr_d : 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (rk_ready) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            last_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            c_q     <= c_d;
                            d_q     <= d_d;
                            round_q <= round_d;
                            last_q  <= last_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign key_ready  = (state_q == IDLE);
    assign rk_valid   = valid_q;
    assign busy       = busy_q;
    assign rk_out     = pc2({c_q, d_q});
    assign rk_round   = round_q;
    assign rk_last    = last_q;
    assign parity_err = perr_q;

endmodule

// File: tb/tb_des_key_sequencer.sv
// Directed bench for des_key_sequencer using the classic 0x133457799BBCDFF1 key schedule.
module tb_des_key_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic        key_ready;
    logic [63:0] key_in;
    logic        decrypt;
    logic        rk_valid;
    logic        rk_ready;
    logic [47:0] rk_out;
    logic [4:0]  rk_round;
    logic        rk_last;
    logic        busy;
    logic        parity_err;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [63:0] KEY    = 64'h133457799BBCDFF1;
    localparam logic [63:0] BADKEY = 64'h123457799BBCDFF1;

    logic [47:0] kt [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    des_key_sequencer #(.PARITY_CHECK(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_in     (key_in),
        .decrypt    (decrypt),
        .rk_valid   (rk_valid),
        .rk_ready   (rk_ready),
        .rk_out     (rk_out),
        .rk_round   (rk_round),
        .rk_last    (rk_last),
        .busy       (busy),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; all sampling and driving happens here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " rk_valid"},  64'(rk_valid),  64'd0);
        chk({tag, " key_ready"}, 64'(key_ready), 64'd1);
        chk({tag, " busy"},      64'(busy),      64'd0);
    endtask

    task automatic drain(input string tag);
        rk_ready = 1'b1;
        for (int n = 0; n < 24 && rk_valid; n++) step();
        chk({tag, " drain"}, 64'(rk_valid), 64'd0);
    endtask

    initial begin
        int idx;
        logic rdy;

        rst       = 1'b1;
        key_valid = 1'b0;
        key_in    = '0;
        decrypt   = 1'b0;
        rk_ready  = 1'b0;

        #3;
        chk("rst key_ready",  64'(key_ready),  64'd1);
        chk("rst rk_valid",   64'(rk_valid),   64'd0);
        chk("rst busy",       64'(busy),       64'd0);
        chk("rst rk_out",     64'(rk_out),     64'd0);
        chk("rst rk_round",   64'(rk_round),   64'd0);
        chk("rst rk_last",    64'(rk_last),    64'd0);
        chk("rst parity_err", 64'(parity_err), 64'd0);
        step();
        rst = 1'b0;
        step();

        // Encrypt with rk_ready held high: 16 keys on consecutive cycles
        key_valid = 1'b1; key_in = KEY; decrypt = 1'b0; rk_ready = 1'b1;
        step();
        key_valid = 1'b0; key_in = '0;
        chk("enc parity_err", 64'(parity_err), 64'd0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("enc K%0d", i + 1),     64'(rk_out),   64'(kt[i]));
            chk($sformatf("enc round%0d", i + 1), 64'(rk_round), 64'(i + 1));
            chk($sformatf("enc last%0d", i + 1),  64'(rk_last),  64'(i == 15));
            chk($sformatf("enc valid%0d", i + 1), 64'(rk_valid), 64'd1);
            chk($sformatf("enc busy%0d", i + 1),  64'(busy),     64'd1);
            step();
        end
        chk_idle("enc end");

        // Random backpressure: same values in order, stable through stalls
        key_valid = 1'b1; key_in = KEY; decrypt = 1'b0;
        step();
        key_valid = 1'b0;
        idx = 0;
        for (int n = 0; n < 400 && idx < 16; n++) begin
            chk($sformatf("bp valid@%0d", idx), 64'(rk_valid), 64'd1);
            chk($sformatf("bp busy@%0d", idx),  64'(busy),     64'd1);
            chk($sformatf("bp K%0d", idx + 1),  64'(rk_out),   64'(kt[idx]));
            chk($sformatf("bp round%0d", idx + 1), 64'(rk_round), 64'(idx + 1));
            chk($sformatf("bp last%0d", idx + 1),  64'(rk_last),  64'(idx == 15));
            rdy = 1'($urandom_range(0, 1));
            rk_ready = rdy;
            step();
            if (rdy) idx++;
        end
        chk("bp count", 64'(idx), 64'd16);
        rk_ready = 1'b1;
        chk_idle("bp end");

        // Bad parity still yields the correct schedule; next good key clears the flag
        key_valid = 1'b1; key_in = BADKEY; decrypt = 1'b0;
        step();
        key_valid = 1'b0;
        chk("par err set", 64'(parity_err), 64'd1);
        chk("par K1",      64'(rk_out),     64'(kt[0]));
        drain("par bad");
        chk("par err hold", 64'(parity_err), 64'd1);
        key_valid = 1'b1; key_in = KEY;
        step();
        key_valid = 1'b0;
        chk("par err clr", 64'(parity_err), 64'd0);
        drain("par good");

        // Key held during RUN (decrypt request) is only taken after the final handshake
        key_valid = 1'b1; key_in = KEY; decrypt = 1'b0;
        step();
        decrypt = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("hold K%0d", i + 1),       64'(rk_out),    64'(kt[i]));
            chk($sformatf("hold key_ready%0d", i + 1), 64'(key_ready), 64'd0);
            step();
        end
        chk("hold no accept valid", 64'(rk_valid),  64'd0);
        chk("hold no accept ready", 64'(key_ready), 64'd1);
        step();
        key_valid = 1'b0; decrypt = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            chk($sformatf("dec K%0d", i + 1),     64'(rk_out),   64'(kt[i]));
            chk($sformatf("dec round%0d", i + 1), 64'(rk_round), 64'(i + 1));
            chk($sformatf("dec last%0d", i + 1),  64'(rk_last),  64'(i == 0));
            chk($sformatf("dec valid%0d", i + 1), 64'(rk_valid), 64'd1);
            step();
        end
        chk_idle("dec end");

        // Asynchronous reset mid-sequence, then a clean reload
        key_valid = 1'b1; key_in = BADKEY; decrypt = 1'b0;
        step();
        key_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("mid round7", 64'(rk_round), 64'd7);
        chk("mid K7",     64'(rk_out),   64'(kt[6]));
        #1 rst = 1'b1;
        #1;
        chk("arst rk_valid",   64'(rk_valid),   64'd0);
        chk("arst busy",       64'(busy),       64'd0);
        chk("arst key_ready",  64'(key_ready),  64'd1);
        chk("arst rk_out",     64'(rk_out),     64'd0);
        chk("arst rk_round",   64'(rk_round),   64'd0);
        chk("arst rk_last",    64'(rk_last),    64'd0);
        chk("arst parity_err", 64'(parity_err), 64'd0);
        #1 rst = 1'b0;
        step();
        chk("post rst idle1", 64'(rk_valid), 64'd0);
        step();
        chk("post rst idle2", 64'(rk_valid), 64'd0);
        key_valid = 1'b1; key_in = KEY; decrypt = 1'b0;
        step();
        key_valid = 1'b0;
        chk("reload K1",     64'(rk_out),     64'(kt[0]));
        chk("reload round",  64'(rk_round),   64'd1);
        chk("reload parity", 64'(parity_err), 64'd0);
        drain("reload");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
